// File: rtl/wb_arb.sv
// Round-robin Wishbone arbiter: NM masters share one decoder/slave bus.
// Grant is held for a master's whole cyc tenure; a watchdog flags stalled strobes.
module wb_arb #(
  parameter int NM  = 2,
  parameter int AW  = 30,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*DW-1:0] m_dat_i,
  output logic [DW-1:0]    m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [DW-1:0]    s_dat_o,
  input  logic [DW-1:0]    s_dat_i,
  input  logic             s_ack_i
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int WW = $clog2(TMO + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TMO - 1);
  localparam logic [GW-1:0] LAST_RST  = GW'(NM - 1);

  logic          busy_q, busy_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] last_q, last_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic          cyc_sel, stb_sel, stall_last;
  logic [GW-1:0] rr_pick;
  logic          rr_hit;

  // Scan starting just after the previous owner so every requester gets a turn.
  always_comb begin
    rr_pick = gnt_q;
    rr_hit  = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      if (!rr_hit && m_cyc_i[(int'(last_q) + i) % NM]) begin
        rr_hit  = 1'b1;
        rr_pick = GW'((int'(last_q) + i) % NM);
      end
    end
  end

  always_comb begin
    cyc_sel    = busy_q & m_cyc_i[gnt_q];
    stb_sel    = cyc_sel & m_stb_i[gnt_q];
    stall_last = stb_sel & ~s_ack_i & (wdog_q == WDOG_LAST);
    s_cyc_o    = cyc_sel;
    s_stb_o    = stb_sel;
    s_we_o     = busy_q & m_we_i[gnt_q];
    s_adr_o    = m_adr_i[int'(gnt_q)*AW +: AW];
    s_dat_o    = m_dat_i[int'(gnt_q)*DW +: DW];
    m_dat_o    = busy_q ? s_dat_i : '0;
    m_ack_o    = '0;
    m_err_o    = '0;
    // Acks and errors are discarded while reset is held.
    if (!rst_i) begin
      m_ack_o[gnt_q] = stb_sel & s_ack_i;
      m_err_o[gnt_q] = stall_last;
    end
  end

  always_comb begin
    busy_d = busy_q;
    gnt_d  = gnt_q;
    last_d = last_q;
    wdog_d = '0;
    if (busy_q) begin
      if (!m_cyc_i[gnt_q]) begin
        busy_d = 1'b0;
        last_d = gnt_q;
      end else if (stb_sel && !s_ack_i) begin
        wdog_d = (wdog_q == WDOG_LAST) ? '0 : wdog_q + WW'(1);
      end
    end else if (rr_hit) begin
      busy_d = 1'b1;
      gnt_d  = rr_pick;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      gnt_q  <= '0;
      last_q <= LAST_RST;
      wdog_q <= '0;
    end else begin
      busy_q <= busy_d;
      gnt_q  <= gnt_d;
      last_q <= last_d;
      wdog_q <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_arb.sv
// Self-checking bench for wb_arb: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration/watchdog model.
module tb_wb_arb;
  localparam int NM = 2, AW = 30, DW = 32, TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [DW-1:0]    m_dat_o, s_dat_o, s_dat_i;
  logic [NM-1:0]    m_ack_o, m_err_o;
  logic             s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [AW-1:0]    s_adr_o;

  int vec = 0;
  int errs = 0;

  wb_arb #(.NM(NM), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
  endtask

  task automatic set_m(input int k, input logic c, input logic s,
                       input logic [AW-1:0] a);
    m_cyc[k] = c;
    m_stb[k] = s;
    m_adr[k*AW +: AW] = a;
    m_dat[k*DW +: DW] = {2'b00, a};
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_cyc = 2'b11; m_stb = 2'b11; s_ack_i = 1'b1;
    next_cycle();
    sample();
    vec++; if (m_err_o !== 2'b00) begin errs++; $display("FAIL reset_err: got %b exp 00", m_err_o); end
    vec++; if (m_ack_o !== 2'b00) begin errs++; $display("FAIL reset_ack: got %b exp 00", m_ack_o); end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    sample();
    vec++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_we_o !== 1'b0)
      begin errs++; $display("FAIL reset_slave: cyc/stb/we=%b%b%b exp 000", s_cyc_o, s_stb_o, s_we_o); end
    vec++; if (m_dat_o !== '0) begin errs++; $display("FAIL reset_mdat: got %h exp 0", m_dat_o); end
    vec++; if (m_err_o !== 2'b00 || m_ack_o !== 2'b00)
      begin errs++; $display("FAIL reset_idle_ack_err: ack=%b err=%b exp 00", m_ack_o, m_err_o); end
  endtask

  task automatic test_single();
    do_reset();
    set_m(0, 1'b1, 1'b1, 30'h0400_0000);
    sample();
    vec++; if (s_cyc_o !== 1'b0) begin errs++; $display("FAIL single_latency: s_cyc_o=%b exp 0", s_cyc_o); end
    next_cycle(); sample();
    vec++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1)
      begin errs++; $display("FAIL single_grant: cyc=%b stb=%b exp 1 1", s_cyc_o, s_stb_o); end
    vec++; if (s_adr_o !== 30'h0400_0000) begin errs++; $display("FAIL single_adr: got %h exp 04000000", s_adr_o); end
    vec++; if (m_ack_o !== 2'b00) begin errs++; $display("FAIL single_early_ack: got %b exp 00", m_ack_o); end
    next_cycle(); sample();
    vec++; if (m_ack_o !== 2'b00) begin errs++; $display("FAIL single_wait_ack: got %b exp 00", m_ack_o); end
    next_cycle();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    sample();
    vec++; if (m_ack_o !== 2'b01) begin errs++; $display("FAIL single_ack: got %b exp 01", m_ack_o); end
    vec++; if (m_dat_o !== 32'hDEAD_BEEF) begin errs++; $display("FAIL single_rdata: got %h exp deadbeef", m_dat_o); end
    next_cycle();
    s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, '0);
    sample();
    vec++; if (m_ack_o !== 2'b00 || s_cyc_o !== 1'b0)
      begin errs++; $display("FAIL single_drop: ack=%b cyc=%b exp 00 0", m_ack_o, s_cyc_o); end
    next_cycle(); sample();
    vec++; if (s_cyc_o !== 1'b0) begin errs++; $display("FAIL single_release: s_cyc_o=%b exp 0", s_cyc_o); end
  endtask

  task automatic test_contention();
    do_reset();
    set_m(0, 1'b1, 1'b0, 30'h0000_0A0A);
    set_m(1, 1'b1, 1'b0, 30'h0000_0B0B);
    next_cycle(); sample();
    vec++; if (s_cyc_o !== 1'b1 || s_adr_o !== 30'h0000_0A0A)
      begin errs++; $display("FAIL contend_first: cyc=%b adr=%h exp 1 00000a0a", s_cyc_o, s_adr_o); end
    next_cycle();
    m_cyc[0] = 1'b0;
    sample();
    vec++; if (s_cyc_o !== 1'b0) begin errs++; $display("FAIL contend_drop: s_cyc_o=%b exp 0", s_cyc_o); end
    next_cycle(); sample();
    vec++; if (s_cyc_o !== 1'b0) begin errs++; $display("FAIL contend_gap: s_cyc_o=%b exp 0", s_cyc_o); end
    next_cycle(); sample();
    vec++; if (s_cyc_o !== 1'b1 || s_adr_o !== 30'h0000_0B0B)
      begin errs++; $display("FAIL contend_second: cyc=%b adr=%h exp 1 00000b0b", s_cyc_o, s_adr_o); end
    next_cycle();
    m_cyc[1] = 1'b0;
    next_cycle();
    m_cyc = 2'b11;
    next_cycle(); sample();
    vec++; if (s_cyc_o !== 1'b1 || s_adr_o !== 30'h0000_0A0A)
      begin errs++; $display("FAIL contend_rotate: cyc=%b adr=%h exp 1 00000a0a", s_cyc_o, s_adr_o); end
    idle_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    set_m(0, 1'b1, 1'b1, 30'h0000_1000);
    next_cycle();
    set_m(1, 1'b1, 1'b1, 30'h0000_2000);
    s_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_adr[0 +: AW] = 30'h0000_1000 + AW'(i);
      sample();
      vec++; if (s_adr_o !== 30'h0000_1000 + AW'(i))
        begin errs++; $display("FAIL hold_adr[%0d]: got %h exp %h", i, s_adr_o, 30'h0000_1000 + AW'(i)); end
      vec++; if (m_ack_o !== 2'b01) begin errs++; $display("FAIL hold_ack[%0d]: got %b exp 01", i, m_ack_o); end
      next_cycle();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack_i = 1'b0;
    sample();
    vec++; if (m_ack_o !== 2'b00 || s_cyc_o !== 1'b0)
      begin errs++; $display("FAIL hold_drop: ack=%b cyc=%b exp 00 0", m_ack_o, s_cyc_o); end
    next_cycle(); sample();
    vec++; if (s_cyc_o !== 1'b0) begin errs++; $display("FAIL hold_gap: s_cyc_o=%b exp 0", s_cyc_o); end
    next_cycle();
    s_ack_i = 1'b1;
    sample();
    vec++; if (s_adr_o !== 30'h0000_2000 || m_ack_o !== 2'b10)
      begin errs++; $display("FAIL hold_next: adr=%h ack=%b exp 00002000 10", s_adr_o, m_ack_o); end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    logic [1:0] exp_err;
    do_reset();
    set_m(0, 1'b1, 1'b1, 30'h3FFF_FFF0);
    next_cycle();
    for (int c = 0; c < 10; c++) begin
      exp_err = (c == TMO - 1) ? 2'b01 : 2'b00;
      sample();
      vec++; if (m_err_o !== exp_err) begin errs++; $display("FAIL wdog_err[%0d]: got %b exp %b", c, m_err_o, exp_err); end
      vec++; if (m_ack_o !== 2'b00) begin errs++; $display("FAIL wdog_ack[%0d]: got %b exp 00", c, m_ack_o); end
      next_cycle();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    sample();
    vec++; if (s_cyc_o !== 1'b0 || m_err_o !== 2'b00)
      begin errs++; $display("FAIL wdog_drop: cyc=%b err=%b exp 0 00", s_cyc_o, m_err_o); end
    next_cycle(); sample();
    vec++; if (s_cyc_o !== 1'b0) begin errs++; $display("FAIL wdog_release: s_cyc_o=%b exp 0", s_cyc_o); end
  endtask

  task automatic test_ack_boundary();
    logic [1:0] exp_err, exp_ack;
    do_reset();
    set_m(0, 1'b1, 1'b1, 30'h0000_0055);
    next_cycle();
    for (int c = 0; c < 16; c++) begin
      s_ack_i = (c == TMO - 1);
      exp_ack = (c == TMO - 1) ? 2'b01 : 2'b00;
      exp_err = (c == 2*TMO - 1) ? 2'b01 : 2'b00;
      sample();
      vec++; if (m_ack_o !== exp_ack) begin errs++; $display("FAIL bound_ack[%0d]: got %b exp %b", c, m_ack_o, exp_ack); end
      vec++; if (m_err_o !== exp_err) begin errs++; $display("FAIL bound_err[%0d]: got %b exp %b", c, m_err_o, exp_err); end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_m(1, 1'b1, 1'b1, 30'h0000_0111);
    next_cycle();
    for (int c = 0; c < TMO - 1; c++) next_cycle();
    rst = 1'b1; s_ack_i = 1'b1;
    sample();
    vec++; if (m_err_o !== 2'b00 || m_ack_o !== 2'b00)
      begin errs++; $display("FAIL rstmid_during: err=%b ack=%b exp 00 00", m_err_o, m_ack_o); end
    next_cycle();
    rst = 1'b0; s_ack_i = 1'b0;
    set_m(0, 1'b1, 1'b1, 30'h0000_0222);
    sample();
    vec++; if (s_cyc_o !== 1'b0 || m_err_o !== 2'b00)
      begin errs++; $display("FAIL rstmid_after: cyc=%b err=%b exp 0 00", s_cyc_o, m_err_o); end
    next_cycle(); sample();
    vec++; if (s_cyc_o !== 1'b1 || s_adr_o !== 30'h0000_0222)
      begin errs++; $display("FAIL rstmid_winner: cyc=%b adr=%h exp 1 00000222", s_cyc_o, s_adr_o); end
    idle_inputs();
  endtask

  // Reference: an owner holds the bus from grant until its cyc drops, then one
  // idle cycle; error on every TMO-th consecutive unacknowledged strobe cycle.
  task automatic test_random();
    bit            busy_m;
    int            own, last_m, run;
    logic          e_cyc, e_stb, e_we;
    logic [NM-1:0] e_ack, e_err;
    bit            found;
    do_reset();
    busy_m = 0; own = 0; last_m = NM - 1; run = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NM; k++) begin
        if ($urandom_range(0, 7) == 0) m_cyc[k] = ~m_cyc[k];
        m_stb[k] = ($urandom_range(0, 7) != 0);
        m_we[k]  = 1'($urandom);
        m_adr[k*AW +: AW] = AW'($urandom);
        m_dat[k*DW +: DW] = $urandom;
      end
      s_ack_i = ($urandom_range(0, 5) == 0);
      s_dat_i = $urandom;
      sample();
      e_cyc = busy_m && m_cyc[own];
      e_stb = e_cyc && m_stb[own];
      e_we  = busy_m && m_we[own];
      e_ack = '0; e_err = '0;
      if (e_stb && s_ack_i) e_ack[own] = 1'b1;
      if (e_stb && !s_ack_i && (run % TMO) == TMO - 1) e_err[own] = 1'b1;
      vec++; if (s_cyc_o !== e_cyc || s_stb_o !== e_stb || s_we_o !== e_we)
        begin errs++; $display("FAIL rand_ctl[%0d]: cyc/stb/we=%b%b%b exp %b%b%b", n, s_cyc_o, s_stb_o, s_we_o, e_cyc, e_stb, e_we); end
      vec++; if (m_ack_o !== e_ack) begin errs++; $display("FAIL rand_ack[%0d]: got %b exp %b", n, m_ack_o, e_ack); end
      vec++; if (m_err_o !== e_err) begin errs++; $display("FAIL rand_err[%0d]: got %b exp %b", n, m_err_o, e_err); end
      vec++; if (m_dat_o !== (busy_m ? s_dat_i : '0))
        begin errs++; $display("FAIL rand_mdat[%0d]: got %h exp %h", n, m_dat_o, busy_m ? s_dat_i : '0); end
      if (busy_m) begin
        vec++; if (s_adr_o !== m_adr[own*AW +: AW] || s_dat_o !== m_dat[own*DW +: DW])
          begin errs++; $display("FAIL rand_mux[%0d]: adr=%h dat=%h exp %h %h", n, s_adr_o, s_dat_o, m_adr[own*AW +: AW], m_dat[own*DW +: DW]); end
      end
      if (busy_m) begin
        if (!m_cyc[own]) begin
          busy_m = 0; last_m = own; run = 0;
        end else if (e_stb && !s_ack_i) run++;
        else run = 0;
      end else if (m_cyc != '0) begin
        found = 0;
        for (int k = 1; k <= NM; k++)
          if (!found && m_cyc[(last_m + k) % NM]) begin found = 1; own = (last_m + k) % NM; end
        busy_m = 1; run = 0;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_adr = '0; m_dat = '0;
    test_reset();
    test_single();
    test_contention();
    test_hold();
    test_watchdog();
    test_ack_boundary();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
